// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by the register file, ALU muxes and datapath.
package riscv_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned REG_ZERO   = 0;

    // True when the index names the hard-wired zero register x0.
    function automatic logic is_reg_zero(input logic [ADDR_WIDTH-1:0] idx);
        return idx == ADDR_WIDTH'(REG_ZERO);
    endfunction

endpackage

// File: rtl/riscv_regfile_rdport.sv
// One combinational read port: forces x0 to zero and, when RISCV_REGFILE_BYPASS_EN
// is defined, forwards same-cycle write data (write-first).
module riscv_regfile_rdport #(
    parameter int unsigned DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic [DATA_WIDTH-1:0] arr_data_i,
    input  logic                  wen_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    import riscv_pkg::*;

    logic raddr_zero;
    assign raddr_zero = (raddr_i == ADDR_WIDTH'(REG_ZERO));

`ifdef RISCV_REGFILE_BYPASS_EN
    logic bypass_hit;
    // wen_i is already qualified with reset and a non-zero write index.
    assign bypass_hit = wen_i && (waddr_i == raddr_i);

    always_comb begin
        rdata_o = arr_data_i;
        if (raddr_zero) begin
            rdata_o = '0;
        end else if (bypass_hit) begin
            rdata_o = wdata_i;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wen_i, waddr_i, wdata_i};

    always_comb begin
        rdata_o = arr_data_i;
        if (raddr_zero) begin
            rdata_o = '0;
        end
    end
`endif

endmodule

// File: rtl/riscv_regfile.sv
// Two-read, one-write RISC-V integer register file with synchronous reset.
// Optional write-first bypass is enabled by defining RISCV_REGFILE_BYPASS_EN.
module riscv_regfile #(
    parameter int unsigned DATA_WIDTH = riscv_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  regwen,
    output logic [DATA_WIDTH-1:0] rs1,
    output logic [DATA_WIDTH-1:0] rs2
);
    import riscv_pkg::*;

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic                  wr_en;

    // Writes to x0 are dropped here; reset overrides any concurrent write.
    assign wr_en = regwen && !rst && (rd_addr != ADDR_WIDTH'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd_addr] = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    riscv_regfile_rdport #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rdport1 (
        .raddr_i   (rs1_addr),
        .arr_data_i(regs_q[rs1_addr]),
        .wen_i     (wr_en),
        .waddr_i   (rd_addr),
        .wdata_i   (rd_data),
        .rdata_o   (rs1)
    );

    riscv_regfile_rdport #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rdport2 (
        .raddr_i   (rs2_addr),
        .arr_data_i(regs_q[rs2_addr]),
        .wen_i     (wr_en),
        .waddr_i   (rd_addr),
        .wdata_i   (rd_data),
        .rdata_o   (rs2)
    );

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed self-checking bench for riscv_regfile; expectations follow
// RISCV_REGFILE_BYPASS_EN when it is defined.
module tb_riscv_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        regwen;
    logic [31:0] rs1;
    logic [31:0] rs2;

    int checks;
    int failures;

    riscv_regfile #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .regwen  (regwen),
        .rs1     (rs1),
        .rs2     (rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        regwen  = 1'b1;
        rd_addr = a;
        rd_data = d;
        tick();
        regwen  = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        regwen = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs1 !== 32'h0) begin
                failures++;
                $display("FAIL reset_rs1 idx=%0d got=%h exp=%h", i, rs1, 32'h0);
            end
            checks++;
            if (rs2 !== 32'h0) begin
                failures++;
                $display("FAIL reset_rs2 idx=%0d got=%h exp=%h", 31 - i, rs2, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        rs2_addr = 5'd5;
        #1;
        checks++;
        if (rs1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_x5_rs1 got=%h exp=%h", rs1, 32'hDEADBEEF);
        end
        checks++;
        if (rs2 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_x5_rs2 got=%h exp=%h", rs2, 32'hDEADBEEF);
        end
    endtask

    task automatic test_x0();
        // Same-cycle read of x0 while writing it: never bypassed.
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        regwen   = 1'b1;
        rd_addr  = 5'd0;
        rd_data  = 32'hFFFFFFFF;
        #1;
        checks++;
        if (rs2 !== 32'h0) begin
            failures++;
            $display("FAIL x0_same_cycle got=%h exp=%h", rs2, 32'h0);
        end
        tick();
        regwen = 1'b0;
        #1;
        checks++;
        if (rs1 !== 32'h0) begin
            failures++;
            $display("FAIL x0_after_write got=%h exp=%h", rs1, 32'h0);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef RISCV_REGFILE_BYPASS_EN
        exp_same = 32'h12345678;
`else
        exp_same = 32'h00000000;
`endif
        rs2_addr = 5'd7;
        rs1_addr = 5'd5;
        regwen   = 1'b1;
        rd_addr  = 5'd7;
        rd_data  = 32'h12345678;
        #1;
        checks++;
        if (rs2 !== exp_same) begin
            failures++;
            $display("FAIL bypass_x7_same got=%h exp=%h", rs2, exp_same);
        end
        checks++;
        if (rs1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_other_port got=%h exp=%h", rs1, 32'hDEADBEEF);
        end
        tick();
        regwen = 1'b0;
        #1;
        checks++;
        if (rs2 !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_x7_after got=%h exp=%h", rs2, 32'h12345678);
        end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd3, 32'hA5A5A5A5);
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (rs1 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL x3_written got=%h exp=%h", rs1, 32'hA5A5A5A5);
        end
        rst     = 1'b1;
        regwen  = 1'b1;
        rd_addr = 5'd3;
        rd_data = 32'h1;
        #1;
        // Pre-reset contents stay visible while rst is high; no bypass under reset.
        checks++;
        if (rs1 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL rst_cycle_view got=%h exp=%h", rs1, 32'hA5A5A5A5);
        end
        tick();
        rst    = 1'b0;
        regwen = 1'b0;
        #1;
        checks++;
        if (rs1 !== 32'h0) begin
            failures++;
            $display("FAIL x3_after_rst got=%h exp=%h", rs1, 32'h0);
        end
    endtask

    task automatic test_write_after_reset();
        logic [31:0] exp_same;
        write_reg(5'd4, 32'h11);
        rs1_addr = 5'd4;
        rst      = 1'b1;
        regwen   = 1'b1;
        rd_addr  = 5'd4;
        rd_data  = 32'h22;
        tick();
        rst     = 1'b0;
        rd_data = 32'h33;
`ifdef RISCV_REGFILE_BYPASS_EN
        exp_same = 32'h33;
`else
        exp_same = 32'h0;
`endif
        #1;
        checks++;
        if (rs1 !== exp_same) begin
            failures++;
            $display("FAIL first_post_rst_view got=%h exp=%h", rs1, exp_same);
        end
        tick();
        regwen = 1'b0;
        #1;
        checks++;
        if (rs1 !== 32'h33) begin
            failures++;
            $display("FAIL first_post_rst_write got=%h exp=%h", rs1, 32'h33);
        end
    endtask

    task automatic test_regwen_off();
        write_reg(5'd9, 32'h77);
        regwen   = 1'b0;
        rd_addr  = 5'd9;
        rd_data  = 32'h55;
        rs1_addr = 5'd9;
        tick();
        tick();
        checks++;
        if (rs1 !== 32'h77) begin
            failures++;
            $display("FAIL regwen_off_x9 got=%h exp=%h", rs1, 32'h77);
        end
    endtask

    task automatic test_independent_ports();
        write_reg(5'd31, 32'hCAFEF00D);
        rs1_addr = 5'd31;
        rs2_addr = 5'd9;
        #1;
        checks++;
        if (rs1 !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL indep_rs1 got=%h exp=%h", rs1, 32'hCAFEF00D);
        end
        checks++;
        if (rs2 !== 32'h77) begin
            failures++;
            $display("FAIL indep_rs2 got=%h exp=%h", rs2, 32'h77);
        end
        rs1_addr = 5'd1;
        rs2_addr = 5'd31;
        #1;
        checks++;
        if (rs1 !== 32'h0) begin
            failures++;
            $display("FAIL indep_rs1_x1 got=%h exp=%h", rs1, 32'h0);
        end
        checks++;
        if (rs2 !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL indep_rs2_x31 got=%h exp=%h", rs2, 32'hCAFEF00D);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        rd_addr  = '0;
        rd_data  = '0;
        regwen   = 1'b0;
        #2;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_reset_priority();
        test_write_after_reset();
        test_regwen_off();
        test_independent_ports();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
